tagged_out_queue: RTL and testbench
===================================

# tagged_out_queue

Buffers the output of the 4-input round-robin arbiter. Each entry holds an 8-bit payload and the 2-bit index of the input that won arbitration. The block sits directly downstream of the arbiter: `enq_*` connects to the arbiter's `io_out_*` and `io_chosen`, and `deq_*` feeds the next consumer. It decouples the consumer's backpressure from the arbiter's grant decision. The queue is a registered FIFO with no flow-through and no pipe-through.

## Interface
- DEPTH, 4, number of entries; must be a power of two, at least 2
- DATA_W, 8, payload width
- ID_W, 2, source-index width
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- enq_valid  in  1  arbiter output valid
- enq_ready  out  1  queue can accept an entry
- enq_bits  in  DATA_W  payload
- enq_id  in  ID_W  winning input index (arbiter chosen)
- deq_valid  out  1  head entry valid
- deq_ready  in  1  consumer accepts the head entry
- deq_bits  out  DATA_W  head payload
- deq_id  out  ID_W  head source index
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- src_pending  out  4*(log2(DEPTH)+1)  per-source occupancy; field k is bits [k*W +: W], with W = log2(DEPTH)+1

## Operation
- Storage: DEPTH-entry array of {id, bits}, with head pointer, tail pointer and a `full` flag. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Empty condition: head == tail and full == 0.
- Full condition: full == 1. When full, head == tail.
- Enqueue fire (enq_fire) = enq_valid & enq_ready. On fire: write {enq_id, enq_bits} at tail, then tail <= tail+1.
- Dequeue fire (deq_fire) = deq_valid & deq_ready. On fire: head <= head+1.
- Handshake outputs:
  - enq_ready = !full. It does not depend on deq_ready; no pipe-through when full.
  - deq_valid = !empty. An entry is never bypassed to `deq_*` in the same cycle it is enqueued.
- `deq_bits` and `deq_id` always show the array entry at head. They are don't-care when deq_valid = 0.
- `full` flag update:
  - Set when enq_fire & !deq_fire and tail+1 == head.
  - Cleared when deq_fire & !enq_fire.
  - Unchanged when both fire.
- `count` update:
  - +1 on enq-only.
  - −1 on deq-only.
  - Unchanged when both fire or neither fires.
- `src_pending[k]` update:
  - +1 when enq_fire with enq_id == k.
  - −1 when deq_fire with deq_id == k.
  - If both apply to the same k in one cycle, the field is unchanged.
  - Invariant: the sum of all fields equals `count`.
- Arbiter interaction: the arbiter advances its round-robin pointer only on `io_out_ready & io_out_valid`, i.e. on enq_fire. A full queue therefore stalls arbitration without changing grant priority.
- Protocol assumptions:
  - enq_valid and payload are held stable until fire.
  - Enqueue while full and dequeue while empty are blocked by the ready/valid gating; no other protection is provided.

## Timing
- Latency: an entry enqueued at edge N is visible on `deq_*` with deq_valid = 1 from cycle N+1. Minimum enq-to-deq latency is 1 cycle.
- Throughput: one enqueue and one dequeue per cycle sustained, at any occupancy from 1 to DEPTH−1.
- At full, enq_ready = 0 for the whole cycle, even when deq_ready = 1. enq_ready returns to 1 in the cycle after a dequeue.
- At empty, deq_valid = 0. Enqueue-only takes the queue to count = 1 in the next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap or bubble.
- Reset values, taking effect at the first clk edge with reset = 1:
  - head = tail = 0, full = 0, count = 0, all src_pending fields = 0.
  - enq_ready = 1 and deq_valid = 0 after that edge.
  - Array contents are not reset.
- Reset asserted mid-operation: all entries are discarded and no handshake fires in that cycle. The state is identical to power-on reset.
- Critical path: enq_ready and deq_valid are driven only by flops, with no combinational input-to-output paths.

## Test plan
- Reset, then fill: push ids 0,1,2,3 with bits 0x10,0x21,0x32,0x43 while deq_ready = 0.
  - After the 4th push: count = 4, enq_ready = 0, every src_pending field = 1.
  - Drain: the queue yields (0,0x10),(1,0x21),(2,0x32),(3,0x43) in order, then deq_valid = 0 and count = 0.
- Full with simultaneous request: at count = 4, enq_valid = 1 and deq_ready = 1 in the same cycle.
  - Only the dequeue fires; count = 3 next cycle.
  - enq_ready = 1 next cycle, and the held entry is accepted on the following edge.
- Streaming: 20 back-to-back entries with enq_valid = 1 and deq_ready = 1 throughout.
  - Output is the input delayed by 1 cycle, with no bubbles after the first.
  - count stays at 1; pointers wrap at least 4 times.
- Empty no-bypass: enqueue (2,0xAA) into an empty queue with deq_ready = 1.
  - deq_valid = 0 in the enqueue cycle.
  - deq_valid = 1, deq_id = 2, deq_bits = 0xAA in the next cycle; count returns to 0 after.
- Per-source counts: enqueue ids 1,1,3, then dequeue one entry.
  - src_pending = {0,1,0,1} for ids {3,2,1,0}, i.e. id1 = 1, id3 = 1, id0 = id2 = 0.
  - count = 2.
- Mid-operation reset: with 3 entries stored, assert reset for 1 cycle during active handshakes.
  - Next cycle: count = 0, deq_valid = 0, enq_ready = 1, all src_pending = 0.
  - A new entry enqueued after reset is the first entry dequeued.

Source files
------------

// File: rtl/tagged_out_queue.sv
// Registered FIFO buffering the round-robin arbiter output: each entry is {source id, payload}.
// Handshake outputs come straight from flops; no flow-through and no pipe-through.
module tagged_out_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  input  logic [ID_W-1:0]   enq_id,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [ID_W-1:0]   deq_id,
  output logic [CW-1:0]     count,
  output logic [4*CW-1:0]   src_pending
);

  localparam int NSRC = 4;

  logic [ID_W+DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [PW-1:0]          tail_next;
  logic                   full;
  logic                   empty;
  logic                   enq_fire;
  logic                   deq_fire;

  assign empty     = (head == tail) && !full;
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign tail_next = tail + PW'(1);

  // Reset cancels any handshake presented in the same cycle.
  assign enq_fire = enq_valid && enq_ready && !reset;
  assign deq_fire = deq_valid && deq_ready && !reset;

  assign {deq_id, deq_bits} = mem[head];

  always_ff @(posedge clk) begin
    if (enq_fire) mem[tail] <= {enq_id, enq_bits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      full  <= 1'b0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail_next;
      if (deq_fire) head <= head + PW'(1);
      if (enq_fire && !deq_fire) begin
        count <= count + CW'(1);
        if (tail_next == head) full <= 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count <= count - CW'(1);
        full  <= 1'b0;
      end
    end
  end

  // Per-source occupancy; an enqueue and dequeue of the same source cancel out.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [CW-1:0] cnt;
    logic          inc;
    logic          dec;

    assign inc = enq_fire && (enq_id == ID_W'(k));
    assign dec = deq_fire && (deq_id == ID_W'(k));

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + CW'(1);
      end else if (dec && !inc) begin
        cnt <= cnt - CW'(1);
      end
    end

    assign src_pending[k*CW +: CW] = cnt;
  end

endmodule

// File: tb/tb_tagged_out_queue.sv
// Scoreboard bench for tagged_out_queue: accepted entries are queued as expected output and
// a monitor compares each dequeued head against them, alongside directed occupancy checks.
module tb_tagged_out_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic [ID_W-1:0]   enq_id;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;
  logic [ID_W-1:0]   deq_id;
  logic [CW-1:0]     count;
  logic [4*CW-1:0]   src_pending;

  logic [ID_W+DATA_W-1:0] exp_q [$];
  int num_compared   = 0;
  int num_mismatched = 0;

  tagged_out_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk),
    .reset(reset),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_bits(enq_bits),
    .enq_id(enq_id),
    .deq_valid(deq_valid),
    .deq_ready(deq_ready),
    .deq_bits(deq_bits),
    .deq_id(deq_id),
    .count(count),
    .src_pending(src_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [DATA_W-1:0] bits,
                               input logic [ID_W-1:0] id, input logic dr);
    enq_valid = ev;
    enq_bits  = bits;
    enq_id    = id;
    deq_ready = dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record every accepted entry as the next expected output.
  always @(negedge clk) begin
    if (!reset && enq_valid && enq_ready) exp_q.push_back({enq_id, enq_bits});
  end

  // Monitor: compare the head whenever a dequeue is about to fire; reset flushes the model.
  always @(negedge clk) begin
    logic [ID_W+DATA_W-1:0] item;
    if (reset) begin
      exp_q.delete();
    end else if (deq_valid && deq_ready) begin
      if (exp_q.size() == 0) begin
        num_compared++;
        num_mismatched++;
        $display("[TB] FAIL unexpected_deq: got id %0d bits 0x%0h, expected nothing", deq_id, deq_bits);
      end else begin
        item = exp_q.pop_front();
        checkOutput("deq_id", 32'(deq_id), 32'(item[ID_W+DATA_W-1:DATA_W]));
        checkOutput("deq_bits", 32'(deq_bits), 32'(item[DATA_W-1:0]));
      end
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_enq_ready", 32'(enq_ready), 32'd1);
    checkOutput("reset_deq_valid", 32'(deq_valid), 32'd0);
    checkOutput("reset_src_pending", 32'(src_pending), 32'h000);

    // Fill four entries with no consumer
    applyStimulus(1'b1, 8'h10, 2'd0, 1'b0); step();
    applyStimulus(1'b1, 8'h21, 2'd1, 1'b0); step();
    applyStimulus(1'b1, 8'h32, 2'd2, 1'b0); step();
    applyStimulus(1'b1, 8'h43, 2'd3, 1'b0); step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_enq_ready", 32'(enq_ready), 32'd0);
    checkOutput("fill_deq_valid", 32'(deq_valid), 32'd1);
    checkOutput("fill_src_pending", 32'(src_pending), 32'h249);

    // Full with simultaneous enqueue and dequeue request
    applyStimulus(1'b1, 8'h54, 2'd0, 1'b1);
    checkOutput("full_enq_ready_blocked", 32'(enq_ready), 32'd0);
    step();
    checkOutput("full_deq_only_count", 32'(count), 32'd3);
    checkOutput("full_enq_ready_back", 32'(enq_ready), 32'd1);
    step();
    checkOutput("full_both_fire_count", 32'(count), 32'd3);
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
    for (int n = 0; n < 8 && count != 0; n++) step();
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_deq_valid", 32'(deq_valid), 32'd0);
    checkOutput("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Streaming: 20 back-to-back entries
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 2'(i % 4), 1'b1);
      step();
      checkOutput("stream_count", 32'(count), 32'd1);
      checkOutput("stream_deq_valid", 32'(deq_valid), 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
    step();
    checkOutput("stream_end_count", 32'(count), 32'd0);

    // Empty queue must not bypass
    applyStimulus(1'b1, 8'hAA, 2'd2, 1'b1);
    checkOutput("nobypass_deq_valid", 32'(deq_valid), 32'd0);
    step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
    checkOutput("nobypass_next_valid", 32'(deq_valid), 32'd1);
    checkOutput("nobypass_next_id", 32'(deq_id), 32'd2);
    checkOutput("nobypass_next_bits", 32'(deq_bits), 32'hAA);
    step();
    checkOutput("nobypass_after_count", 32'(count), 32'd0);
    checkOutput("nobypass_after_valid", 32'(deq_valid), 32'd0);

    // Per-source counters
    applyStimulus(1'b1, 8'h11, 2'd1, 1'b0); step();
    applyStimulus(1'b1, 8'h12, 2'd1, 1'b0); step();
    applyStimulus(1'b1, 8'h13, 2'd3, 1'b0); step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1); step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("src_pending_mix", 32'(src_pending), 32'h208);
    checkOutput("src_count", 32'(count), 32'd2);

    // Reset in the middle of active handshakes with three entries stored
    applyStimulus(1'b1, 8'h21, 2'd0, 1'b0); step();
    checkOutput("pre_reset_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 8'h31, 2'd2, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("midreset_count", 32'(count), 32'd0);
    checkOutput("midreset_deq_valid", 32'(deq_valid), 32'd0);
    checkOutput("midreset_enq_ready", 32'(enq_ready), 32'd1);
    checkOutput("midreset_src_pending", 32'(src_pending), 32'h000);
    applyStimulus(1'b1, 8'h5A, 2'd1, 1'b0); step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
    checkOutput("postreset_head_id", 32'(deq_id), 32'd1);
    checkOutput("postreset_head_bits", 32'(deq_bits), 32'h5A);
    step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("postreset_count", 32'(count), 32'd0);
    checkOutput("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
